dust16_core: RTL and testbench

Minimal 8-bit-bus, 16-bit-datapath accumulator CPU; the top-level processing element of the dust16 system. It fetches variable-length instructions from a byte-wide synchronous memory port and executes load, store, ALU and jump operations on a 16-bit accumulator and four 16-bit registers. All memory traffic, including fetch, uses the single `m_*` port, which supports wait-state stalls.

---
 rtl/dust16_core.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dust16_core.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dust16_core.sv
// dust16_core: 8-bit-bus, 16-bit-datapath accumulator CPU.
// A single byte-wide bus serves both instruction fetch and data traffic.
// Every bus output is registered. A cycle stalled by m_wait freezes all state.
module dust16_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_wait,
  input  logic [7:0]  m_idata,
  output logic [7:0]  m_odata,
  output logic [15:0] m_addr,
  output logic        m_cs,
  output logic        m_we
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_IMM_LO = 3'd1,
    ST_IMM_HI = 3'd2,
    ST_MEM_LO = 3'd3,
    ST_MEM_HI = 3'd4,
    ST_EXEC   = 3'd5
  } state_t;

  // Architectural and control state
  state_t      state_r;
  logic [15:0] pc_r;
  logic [15:0] a_r;
  logic        c_r;
  logic [7:0]  ir_r;
  logic [7:0]  tmp_r;
  logic [15:0] regs_r [4];

  // Registered bus outputs
  logic [15:0] m_addr_r;
  logic [7:0]  m_odata_r;
  logic        m_cs_r;
  logic        m_we_r;

  // Next-state values
  state_t      state_nx_s;
  logic [15:0] pc_nx_s;
  logic [15:0] a_nx_s;
  logic        c_nx_s;
  logic [7:0]  ir_nx_s;
  logic [7:0]  tmp_nx_s;
  logic        reg_we_s;
  logic [1:0]  reg_sel_s;
  logic [15:0] reg_wdata_s;
  logic [15:0] addr_nx_s;
  logic [7:0]  odata_nx_s;
  logic        cs_nx_s;
  logic        we_nx_s;

  // Datapath helpers
  logic [15:0] rn_s;
  logic [15:0] fetch_rn_s;
  logic [15:0] imm16_s;
  logic [15:0] pc_inc_s;
  logic [16:0] add_s;
  logic        advance_s;

  assign rn_s       = regs_r[ir_r[1:0]];
  assign fetch_rn_s = regs_r[m_idata[1:0]];
  assign imm16_s    = {m_idata, tmp_r};
  assign pc_inc_s   = pc_r + 16'd1;
  assign add_s      = {1'b0, a_r} + {1'b0, rn_s};
  // A cycle without m_cs is internal and never stalls; a bus cycle waits for m_wait low.
  assign advance_s  = ~m_cs_r | ~m_wait;

  assign m_addr  = m_addr_r;
  assign m_odata = m_odata_r;
  assign m_cs    = m_cs_r;
  assign m_we    = m_we_r;

  // Next-state, datapath and next-bus-cycle decode for the instruction sequencer
  always_comb begin
    state_nx_s  = state_r;
    pc_nx_s     = pc_r;
    a_nx_s      = a_r;
    c_nx_s      = c_r;
    ir_nx_s     = ir_r;
    tmp_nx_s    = tmp_r;
    reg_we_s    = 1'b0;
    reg_sel_s   = ir_r[1:0];
    reg_wdata_s = a_r;
    addr_nx_s   = m_addr_r;
    odata_nx_s  = 8'h00;
    cs_nx_s     = 1'b0;
    we_nx_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        cs_nx_s = 1'b1;
        if (!m_cs_r) begin
          // First cycle after reset: put the fetch on the bus
          addr_nx_s = pc_r;
        end else begin
          ir_nx_s = m_idata;
          pc_nx_s = pc_inc_s;
          case (m_idata[7:4])
            4'h0, 4'h1, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF: begin
              state_nx_s = ST_IMM_LO;
              addr_nx_s  = pc_inc_s;
            end
            4'h2, 4'h3: begin
              state_nx_s = ST_MEM_LO;
              addr_nx_s  = fetch_rn_s;
            end
            4'h4, 4'h5: begin
              state_nx_s = ST_MEM_LO;
              addr_nx_s  = fetch_rn_s;
              we_nx_s    = 1'b1;
              odata_nx_s = a_r[7:0];
            end
            default: begin
              state_nx_s = ST_EXEC;
              cs_nx_s    = 1'b0;
            end
          endcase
        end
      end
      ST_IMM_LO: begin
        pc_nx_s   = pc_inc_s;
        tmp_nx_s  = m_idata;
        cs_nx_s   = 1'b1;
        addr_nx_s = pc_inc_s;
        if (ir_r[7:4] == 4'h0) begin
          a_nx_s     = {8'h00, m_idata};
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_IMM_HI;
        end
      end
      ST_IMM_HI: begin
        state_nx_s = ST_FETCH;
        cs_nx_s    = 1'b1;
        case (ir_r[7:4])
          4'h1: begin
            a_nx_s  = imm16_s;
            pc_nx_s = pc_inc_s;
          end
          4'h7: begin
            reg_we_s    = 1'b1;
            reg_wdata_s = pc_inc_s;
            pc_nx_s     = imm16_s;
          end
          4'hC, 4'hD: begin
            pc_nx_s = imm16_s;
          end
          4'hE: begin
            if (c_r) begin
              pc_nx_s = imm16_s;
            end else begin
              pc_nx_s = pc_inc_s;
            end
          end
          4'hF: begin
            if (a_r == 16'h0000) begin
              pc_nx_s = imm16_s;
            end else begin
              pc_nx_s = pc_inc_s;
            end
          end
          default: begin
            pc_nx_s = pc_inc_s;
          end
        endcase
        addr_nx_s = pc_nx_s;
      end
      ST_MEM_LO: begin
        tmp_nx_s = m_idata;
        cs_nx_s  = 1'b1;
        if (ir_r[4]) begin
          // Word access: second byte at the next address, wrapping at 64K
          state_nx_s = ST_MEM_HI;
          addr_nx_s  = m_addr_r + 16'd1;
          we_nx_s    = ir_r[6];
          odata_nx_s = ir_r[6] ? a_r[15:8] : 8'h00;
        end else begin
          state_nx_s = ST_FETCH;
          addr_nx_s  = pc_r;
          if (!ir_r[6]) begin
            a_nx_s = {8'h00, m_idata};
          end else begin
            a_nx_s = a_r;
          end
        end
      end
      ST_MEM_HI: begin
        state_nx_s = ST_FETCH;
        cs_nx_s    = 1'b1;
        addr_nx_s  = pc_r;
        if (!ir_r[6]) begin
          a_nx_s = {m_idata, tmp_r};
        end else begin
          a_nx_s = a_r;
        end
      end
      ST_EXEC: begin
        state_nx_s = ST_FETCH;
        cs_nx_s    = 1'b1;
        addr_nx_s  = pc_r;
        case (ir_r[7:2])
          6'b100001: a_nx_s = rn_s;
          6'b100010: {c_nx_s, a_nx_s} = add_s;
          6'b100011: begin
            a_nx_s = a_r - rn_s;
            c_nx_s = (a_r < rn_s);
          end
          6'b100100: a_nx_s = a_r & rn_s;
          6'b100101: a_nx_s = a_r | rn_s;
          6'b100110: a_nx_s = a_r ^ rn_s;
          6'b100111: begin
            a_nx_s = {c_r, a_r[15:1]};
            c_nx_s = a_r[0];
          end
          6'b101000: begin
            reg_we_s    = 1'b1;
            reg_wdata_s = a_r;
          end
          default: a_nx_s = a_r;
        endcase
      end
      default: begin
        state_nx_s = ST_FETCH;
        addr_nx_s  = 16'h0000;
      end
    endcase
  end

  // State and bus output registers; nothing moves while a bus cycle is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      pc_r      <= 16'h0000;
      a_r       <= 16'h0000;
      c_r       <= 1'b0;
      ir_r      <= 8'h00;
      tmp_r     <= 8'h00;
      regs_r[0] <= 16'h0000;
      regs_r[1] <= 16'h0000;
      regs_r[2] <= 16'h0000;
      regs_r[3] <= 16'h0000;
      m_addr_r  <= 16'h0000;
      m_odata_r <= 8'h00;
      m_cs_r    <= 1'b0;
      m_we_r    <= 1'b0;
    end else if (advance_s) begin
      state_r   <= state_nx_s;
      pc_r      <= pc_nx_s;
      a_r       <= a_nx_s;
      c_r       <= c_nx_s;
      ir_r      <= ir_nx_s;
      tmp_r     <= tmp_nx_s;
      m_addr_r  <= addr_nx_s;
      m_odata_r <= odata_nx_s;
      m_cs_r    <= cs_nx_s;
      m_we_r    <= we_nx_s;
      if (reg_we_s) begin
        regs_r[reg_sel_s] <= reg_wdata_s;
      end
    end
  end

endmodule

// File: tb/tb_dust16_core.sv
// Directed testbench for dust16_core: a byte memory model feeds the bus, and
// every completed write is matched against a queue of expected writes.
module tb_dust16_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_wait;
  logic [7:0]  m_idata;
  logic [7:0]  m_odata;
  logic [15:0] m_addr;
  logic        m_cs;
  logic        m_we;

  logic [7:0]  rom   [65536];
  logic [7:0]  wmem  [65536];
  bit          wvalid[65536];
  logic [23:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  // Free-running clock
  always #5 clk = ~clk;

  // Combinational read port: written bytes overlay the program image
  assign m_idata = wvalid[m_addr] ? wmem[m_addr] : rom[m_addr];

  dust16_core dut (
    .clk    (clk),
    .rst    (rst),
    .m_wait (m_wait),
    .m_idata(m_idata),
    .m_odata(m_odata),
    .m_addr (m_addr),
    .m_cs   (m_cs),
    .m_we   (m_we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [15:0] a, input logic [7:0] d);
    rom[a] = d;
  endtask

  // Advance one clock; a write completing at this edge is checked and stored
  task automatic cycle();
    logic [23:0] e;
    if (m_cs === 1'b1 && m_we === 1'b1 && m_wait === 1'b0) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 24'hxxxxxx;
      chk("bus_write", {8'h00, m_addr, m_odata}, {8'h00, e});
      wvalid[m_addr] = 1'b1;
      wmem[m_addr]   = m_odata;
    end
    @(negedge clk);
  endtask

  // Advance until a given read/write bus cycle is on the bus, within a budget
  task automatic wait_bus(input string tag, input logic [15:0] addr, input int budget);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      if (m_cs === 1'b1 && m_we === 1'b0 && m_addr === addr) found = 1'b1;
      else cycle();
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    rst    = 1'b1;
    m_wait = 1'b0;
    for (int i = 0; i < 65536; i++) rom[i] = 8'h80;
    // Program
    put(16'h0000, 8'hC0); put(16'h0001, 8'h00); put(16'h0002, 8'h01); // JMP 0x0100
    put(16'h0100, 8'h10); put(16'h0101, 8'h08); put(16'h0102, 8'h00); // LDI_W 0x0008
    put(16'h0103, 8'hA0);                                             // MVX R0
    put(16'h0104, 8'h10); put(16'h0105, 8'hEF); put(16'h0106, 8'hBE); // LDI_W 0xBEEF
    put(16'h0107, 8'h50);                                             // STM_W R0
    put(16'h0108, 8'h10); put(16'h0109, 8'h01); put(16'h010A, 8'h00); // LDI_W 0x0001
    put(16'h010B, 8'hA1);                                             // MVX R1
    put(16'h010C, 8'h10); put(16'h010D, 8'hFF); put(16'h010E, 8'hFF); // LDI_W 0xFFFF
    put(16'h010F, 8'h89);                                             // ADD R1
    put(16'h0110, 8'hE0); put(16'h0111, 8'h20); put(16'h0112, 8'h01); // JCS 0x0120
    put(16'h0113, 8'h43);                                             // trap: STM_B R3
    put(16'h0120, 8'hF0); put(16'h0121, 8'h30); put(16'h0122, 8'h01); // JZA 0x0130
    put(16'h0123, 8'h43);                                             // trap
    put(16'h0130, 8'h50);                                             // STM_W R0 (A=0)
    put(16'h0131, 8'h00); put(16'h0132, 8'h02);                       // LDI_B 0x02
    put(16'h0133, 8'h9C);                                             // ROR
    put(16'h0134, 8'h50);                                             // STM_W R0
    put(16'h0135, 8'hE0); put(16'h0136, 8'h00); put(16'h0137, 8'h02); // JCS 0x0200
    put(16'h0138, 8'h40);                                             // STM_B R0
    put(16'h0139, 8'h10); put(16'h013A, 8'h00); put(16'h013B, 8'h03); // LDI_W 0x0300
    put(16'h013C, 8'hA3);                                             // MVX R3
    put(16'h013D, 8'h30);                                             // LDM_W R0
    put(16'h013E, 8'h53);                                             // STM_W R3
    put(16'h013F, 8'hC0); put(16'h0140, 8'h10); put(16'h0141, 8'h00); // JMP 0x0010
    put(16'h0010, 8'h72); put(16'h0011, 8'h40); put(16'h0012, 8'h00); // JAL_W R2,0x0040
    put(16'h0040, 8'h86);                                             // MVA R2
    put(16'h0041, 8'h53);                                             // STM_W R3
    put(16'h0042, 8'hC0); put(16'h0043, 8'hFF); put(16'h0044, 8'hFF); // JMP 0xFFFF
    put(16'h0200, 8'h43);                                             // trap
    // Expected writes, in order
    exp_q.push_back({16'h0008, 8'hEF}); exp_q.push_back({16'h0009, 8'hBE});
    exp_q.push_back({16'h0008, 8'h00}); exp_q.push_back({16'h0009, 8'h00});
    exp_q.push_back({16'h0008, 8'h01}); exp_q.push_back({16'h0009, 8'h80});
    exp_q.push_back({16'h0008, 8'h01});
    exp_q.push_back({16'h0300, 8'h01}); exp_q.push_back({16'h0301, 8'h80});
    exp_q.push_back({16'h0300, 8'h13}); exp_q.push_back({16'h0301, 8'h00});

    // Reset held for three edges
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_cs", {31'd0, m_cs}, 32'd0);
      chk("rst_we", {31'd0, m_we}, 32'd0);
      chk("rst_addr", {16'd0, m_addr}, 32'd0);
      chk("rst_odata", {24'd0, m_odata}, 32'd0);
      if (i < 2) cycle();
    end
    rst = 1'b0;
    cycle();
    chk("first_fetch_cs", {31'd0, m_cs}, 32'd1);
    chk("first_fetch_addr", {16'd0, m_addr}, 32'h0000);
    chk("first_fetch_we", {31'd0, m_we}, 32'd0);

    // Wait states on the low-byte read of LDM_W R0
    wait_bus("ldm_lo_reached", 16'h0008, 2000);
    m_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("wait_addr", {16'd0, m_addr}, 32'h0008);
      chk("wait_cs", {31'd0, m_cs}, 32'd1);
      chk("wait_we", {31'd0, m_we}, 32'd0);
    end
    m_wait = 1'b0;
    cycle();
    chk("ldm_hi_addr", {16'd0, m_addr}, 32'h0009);
    chk("ldm_hi_cs", {31'd0, m_cs}, 32'd1);

    // JAL_W: fetch after the high immediate comes from the target
    wait_bus("jal_hi_reached", 16'h0012, 500);
    cycle();
    chk("jal_target_addr", {16'd0, m_addr}, 32'h0040);
    chk("jal_target_cs", {31'd0, m_cs}, 32'd1);

    // PC wrap: NOP at 0xFFFF, then fetch at 0x0000
    wait_bus("wrap_fetch_reached", 16'hFFFF, 500);
    cycle();
    chk("exec_cs", {31'd0, m_cs}, 32'd0);
    cycle();
    chk("wrap_addr", {16'd0, m_addr}, 32'h0000);
    chk("wrap_cs", {31'd0, m_cs}, 32'd1);
    chk("pending_writes", exp_q.size(), 32'd0);

    // Reset during a fetch aborts it
    rst = 1'b1;
    cycle();
    chk("rst2_cs", {31'd0, m_cs}, 32'd0);
    chk("rst2_we", {31'd0, m_we}, 32'd0);
    chk("rst2_addr", {16'd0, m_addr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
